key_debounce_multi: RTL

//  N-channel key conditioner for active-low push-buttons/keypad lines.
//  Per channel: 2-flop synchroniser, prescaled sampling, N-sample stable debounce,
//  one-clock press/release pulses, optional typematic auto-repeat.

---
 rtl/key_debounce_pkg.sv | 27 ++
 rtl/key_debounce_chan.sv | 180 ++++++++++++++++++
 rtl/key_debounce_multi.sv | 88 ++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared channel state type and width helpers for the key conditioner
package key_debounce_pkg;

  // Per-channel conditioner states, shared by every channel instance.
  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } key_state_t;

  // Bits needed to index/count n values, never less than 1 so 1-wide buses stay legal.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key channel: synchroniser, debounce FSM, auto-repeat, pulses
//
// Ports:
//   clk, resetN   clock, asynchronous active-low reset
//   keyN          raw active-low key pin, asynchronous to clk
//   sampleTick    one-clk enable from the shared prescaler; all FSM state moves on it
//   keyLevel      debounced level, 1 = pressed
//   pressPulse    one-clk pulse when a press is accepted
//   releasePulse  one-clk pulse when a release is accepted
//   repeatPulse   one-clk pulse per auto-repeat event
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_EN        = 1,
  parameter int REPEAT_DELAY     = 32,
  parameter int REPEAT_RATE      = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic keyN,
  input  logic sampleTick,
  output logic keyLevel,
  output logic pressPulse,
  output logic releasePulse,
  output logic repeatPulse
);

  localparam int DB_W  = clog2_min1(DEBOUNCE_SAMPLES + 1);
  localparam int RPT_W = clog2_min1(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SAMPLES);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] DELAY_T   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RATE_T    = RPT_W'(REPEAT_RATE);

  logic             syncA;
  logic             syncB;
  logic             sample;
  key_state_t       state;
  logic [DB_W-1:0]  dbCnt;
  logic [RPT_W-1:0] rptCnt;
  logic [DB_W-1:0]  dbInc;
  logic [RPT_W-1:0] rptInc;

  // Synchroniser resets to 1 so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
    end else begin
      syncA <= keyN;
      syncB <= syncA;
    end
  end

  assign sample = ~syncB;

  // Saturating increments: the FSM leaves a counting state on reaching its target,
  // so saturation only guards against a corrupted count ever wrapping back.
  assign dbInc  = (dbCnt == '1)  ? dbCnt  : dbCnt + DB_ONE;
  assign rptInc = (rptCnt == '1) ? rptCnt : rptCnt + RPT_ONE;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      dbCnt        <= '0;
      rptCnt       <= '0;
      keyLevel     <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse  <= 1'b0;
    end else begin
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse  <= 1'b0;
      if (sampleTick) begin
        case (state)
          IDLE: begin
            if (sample) begin
              if (DEBOUNCE_SAMPLES == 1) begin
                state      <= HELD;
                keyLevel   <= 1'b1;
                pressPulse <= 1'b1;
                dbCnt      <= '0;
                rptCnt     <= '0;
              end else begin
                state <= DB_PRESS;
                dbCnt <= DB_ONE;
              end
            end
          end
          DB_PRESS: begin
            if (sample) begin
              if (dbInc == DB_TARGET) begin
                state      <= HELD;
                keyLevel   <= 1'b1;
                pressPulse <= 1'b1;
                dbCnt      <= '0;
                rptCnt     <= '0;
              end else begin
                dbCnt <= dbInc;
              end
            end else begin
              // Glitch shorter than the debounce window: drop it silently.
              state <= IDLE;
              dbCnt <= '0;
            end
          end
          HELD: begin
            if (!sample) begin
              rptCnt <= '0;
              if (DEBOUNCE_SAMPLES == 1) begin
                state        <= IDLE;
                keyLevel     <= 1'b0;
                releasePulse <= 1'b1;
                dbCnt        <= '0;
              end else begin
                state <= DB_RELEASE;
                dbCnt <= DB_ONE;
              end
            end else if (REPEAT_EN != 0) begin
              if (rptInc == DELAY_T) begin
                state       <= REPEAT;
                repeatPulse <= 1'b1;
                rptCnt      <= '0;
              end else begin
                rptCnt <= rptInc;
              end
            end
          end
          REPEAT: begin
            if (!sample) begin
              rptCnt <= '0;
              if (DEBOUNCE_SAMPLES == 1) begin
                state        <= IDLE;
                keyLevel     <= 1'b0;
                releasePulse <= 1'b1;
                dbCnt        <= '0;
              end else begin
                state <= DB_RELEASE;
                dbCnt <= DB_ONE;
              end
            end else if (rptInc == RATE_T) begin
              repeatPulse <= 1'b1;
              rptCnt      <= '0;
            end else begin
              rptCnt <= rptInc;
            end
          end
          DB_RELEASE: begin
            if (!sample) begin
              if (dbInc == DB_TARGET) begin
                state        <= IDLE;
                keyLevel     <= 1'b0;
                releasePulse <= 1'b1;
                dbCnt        <= '0;
              end else begin
                dbCnt <= dbInc;
              end
            end else begin
              // Release bounce: key is still down, resume holding without a new press
              // and restart the repeat delay from zero.
              state  <= HELD;
              dbCnt  <= '0;
              rptCnt <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            dbCnt  <= '0;
            rptCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N-channel debounced key conditioner with press/release/repeat events
//
// Ports:
//   clk, resetN   clock, asynchronous active-low reset
//   keyN          raw active-low key pins, asynchronous to clk
//   keyLevel      debounced levels, 1 = pressed
//   pressPulse    per-key one-clk accepted-press pulses
//   releasePulse  per-key one-clk accepted-release pulses
//   repeatPulse   per-key one-clk auto-repeat pulses
//   anyPressed    OR of keyLevel
//   eventValid    any press or repeat pulse this cycle (releases excluded)
//   eventCode     lowest key index with a press or repeat pulse, 0 when idle
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS         = 4,
  parameter int SAMPLE_DIV       = 16,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_EN        = 1,
  parameter int REPEAT_DELAY     = 32,
  parameter int REPEAT_RATE      = 8,
  localparam int CODE_W          = clog2_min1(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [NUM_KEYS-1:0] keyN,
  output logic [NUM_KEYS-1:0] keyLevel,
  output logic [NUM_KEYS-1:0] pressPulse,
  output logic [NUM_KEYS-1:0] releasePulse,
  output logic [NUM_KEYS-1:0] repeatPulse,
  output logic                anyPressed,
  output logic                eventValid,
  output logic [CODE_W-1:0]   eventCode
);

  localparam int PS_W = clog2_min1(SAMPLE_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SAMPLE_DIV - 1);

  logic [PS_W-1:0]     psCnt;
  logic                sampleTick;
  logic [NUM_KEYS-1:0] hits;

  assign sampleTick = (psCnt == PS_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      psCnt <= '0;
    end else if (sampleTick) begin
      psCnt <= '0;
    end else begin
      psCnt <= psCnt + PS_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gChan
    key_debounce_chan #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) uChan (
      .clk         (clk),
      .resetN      (resetN),
      .keyN        (keyN[k]),
      .sampleTick  (sampleTick),
      .keyLevel    (keyLevel[k]),
      .pressPulse  (pressPulse[k]),
      .releasePulse(releasePulse[k]),
      .repeatPulse (repeatPulse[k])
    );
  end

  assign anyPressed = |keyLevel;

  // Built from registered pulses, so eventValid/eventCode line up with the pulse cycle.
  // Scanning downward lets the lowest set index win.
  always_comb begin
    hits       = pressPulse | repeatPulse;
    eventValid = |hits;
    eventCode  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        eventCode = CODE_W'(i);
      end
    end
  end

endmodule
